// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding buffer and optional even parity.
// Frames back-to-back with no idle gap whenever a byte is waiting.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       CLK50MHz,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, nstate;
  logic [15:0] cnt, ncnt;
  logic [2:0]  idx, nidx;
  logic [7:0]  shreg, nshreg;
  logic [7:0]  hold, nhold;
  logic        par, npar;
  logic        full, nfull;
  logic        tx_q, ntx;
  logic        done_q;
  logic        accept;
  logic        last;
  logic        fin;

  assign accept = VALID & ~full;
  assign last   = (cnt == LAST);
  assign fin    = (state == S_STOP) & last;

  assign READY = ~full;
  assign BUSY  = (state != S_IDLE);
  assign TX    = tx_q;
  assign DONE  = done_q;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = idx;
    nshreg = shreg;
    npar   = par;
    nhold  = hold;
    nfull  = full;
    ntx    = 1'b1;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          nstate = S_START;
          ncnt   = '0;
          nshreg = DATA;
          npar   = ^DATA;
        end
      end
      S_START: begin
        if (last) begin
          nstate = S_DATA;
          nidx   = '0;
          ncnt   = '0;
        end else begin
          ncnt = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (last) begin
          ncnt = '0;
          if (idx == 3'd7) begin
            nstate = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            nidx = idx + 3'd1;
          end
        end else begin
          ncnt = cnt + 16'd1;
        end
      end
      S_PARITY: begin
        if (last) begin
          nstate = S_STOP;
          ncnt   = '0;
        end else begin
          ncnt = cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (last) begin
          ncnt = '0;
          if (full) begin
            nstate = S_START;
            nshreg = hold;
            npar   = ^hold;
            nfull  = 1'b0;
          end else if (accept) begin
            nstate = S_START;
            nshreg = DATA;
            npar   = ^DATA;
          end else begin
            nstate = S_IDLE;
          end
        end else begin
          ncnt = cnt + 16'd1;
        end
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
    endcase

    // engine busy and not about to reload: park the byte
    if (accept && state != S_IDLE && !fin) begin
      nfull = 1'b1;
      nhold = DATA;
    end

    unique case (nstate)
      S_START:  ntx = 1'b0;
      S_DATA:   ntx = nshreg[nidx];
      S_PARITY: ntx = npar;
      default:  ntx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK50MHz or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      hold   <= '0;
      full   <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      idx    <= nidx;
      shreg  <= nshreg;
      par    <= npar;
      hold   <= nhold;
      full   <= nfull;
      tx_q   <= ntx;
      done_q <= fin;
    end
  end

endmodule
